// File: rtl/noc_route_arbiter.sv
// rtl/noc_route_arbiter.sv - credit-based 5-port mesh router core with Y-first routing and round-robin output arbitration
//
// Ports (index 0=N, 1=S, 2=E, 3=W, 4=L everywhere):
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_data    per-port input head flits (port i at [i*DATA_W +: DATA_W])
//   in_ready            combinational: head granted or dropped this cycle
//   out_valid/out_data  registered one-cycle flit strobe and flit per output
//   out_sel             registered 3-bit winning input index per output
//   credit_ret          one-cycle pulse per output: downstream freed one slot
//   drop_cnt            saturating count of flits dropped for illegal turns
//   credit_err          sticky: credit returned while counter already full
module noc_route_arbiter #(
    parameter int XCOORD  = 1,
    parameter int YCOORD  = 1,
    parameter int COORD_W = 4,
    parameter int DATA_W  = 8,
    parameter int CREDITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [4:0]          in_valid,
    input  logic [5*DATA_W-1:0] in_data,
    output logic [4:0]          in_ready,
    output logic [4:0]          out_valid,
    output logic [5*DATA_W-1:0] out_data,
    output logic [14:0]         out_sel,
    input  logic [4:0]          credit_ret,
    output logic [15:0]         drop_cnt,
    output logic                credit_err
);
    localparam int NP = 5;
    localparam int CW = $clog2(CREDITS + 1);
    localparam logic [COORD_W-1:0] XC = COORD_W'(XCOORD);
    localparam logic [COORD_W-1:0] YC = COORD_W'(YCOORD);
    localparam logic [CW-1:0] CFULL = CW'(CREDITS);

    logic [DATA_W-1:0]  flit  [NP];
    logic [2:0]         route [NP];
    logic [NP-1:0]      legal;
    logic [NP-1:0]      drop;
    logic [NP-1:0]      req   [NP];   // req[o][i]: input i wants output o
    logic [NP-1:0]      gnt   [NP];   // gnt[o][i]
    logic [2:0]         win   [NP];
    logic [NP-1:0]      hit;
    logic [DATA_W-1:0]  oflit [NP];
    logic [NP-1:0]      any_gnt;
    logic [2:0]         ndrop;

    logic [CW-1:0]      cred  [NP];
    logic [NP-1:0]      rr    [NP];

    // Dimension-ordered routing forbids turning back into Y after X,
    // and U-turns are never legal.
    function automatic logic turn_ok(input int unsigned src, input logic [2:0] dst);
        case (src)
            0:       return dst != 3'd0;
            1:       return dst != 3'd1;
            2:       return (dst == 3'd3) || (dst == 3'd4);
            3:       return (dst == 3'd2) || (dst == 3'd4);
            default: return dst != 3'd4;
        endcase
    endfunction

    always_comb begin
        for (int i = 0; i < NP; i++) begin
            flit[i] = in_data[i*DATA_W +: DATA_W];
            if (flit[i][COORD_W-1:0] > YC)
                route[i] = 3'd1;
            else if (flit[i][COORD_W-1:0] < YC)
                route[i] = 3'd0;
            else if (flit[i][2*COORD_W-1:COORD_W] > XC)
                route[i] = 3'd2;
            else if (flit[i][2*COORD_W-1:COORD_W] < XC)
                route[i] = 3'd3;
            else
                route[i] = 3'd4;
            legal[i] = turn_ok(i, route[i]);
            drop[i]  = in_valid[i] & ~legal[i];
        end

        ndrop   = '0;
        any_gnt = '0;
        for (int i = 0; i < NP; i++)
            ndrop = ndrop + {2'b00, drop[i]};

        for (int o = 0; o < NP; o++) begin
            int unsigned pidx;
            int unsigned idx;
            pidx     = 0;
            gnt[o]   = '0;
            win[o]   = '0;
            hit[o]   = 1'b0;
            oflit[o] = '0;
            for (int i = 0; i < NP; i++) begin
                req[o][i] = in_valid[i] & legal[i] & (route[i] == 3'(o));
                if (rr[o][i])
                    pidx = i;
            end
            // Scan cyclically from the pointer; grant only with a credit in hand.
            for (int k = 0; k < NP; k++) begin
                idx = pidx + k;
                if (idx >= NP)
                    idx = idx - NP;
                if (!hit[o] && req[o][idx] && cred[o] != '0) begin
                    hit[o]      = 1'b1;
                    win[o]      = 3'(idx);
                    gnt[o][idx] = 1'b1;
                    oflit[o]    = flit[idx];
                end
            end
            any_gnt = any_gnt | gnt[o];
        end

        in_ready = rst_n ? (any_gnt | drop) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= '0;
            out_data   <= '0;
            out_sel    <= '0;
            drop_cnt   <= '0;
            credit_err <= 1'b0;
            for (int o = 0; o < NP; o++) begin
                cred[o] <= CFULL;
                rr[o]   <= 5'b00001;
            end
        end else begin
            logic [16:0] dsum;
            dsum     = {1'b0, drop_cnt} + 17'(ndrop);
            drop_cnt <= dsum[16] ? 16'hFFFF : dsum[15:0];
            for (int o = 0; o < NP; o++) begin
                out_valid[o] <= hit[o];
                if (hit[o]) begin
                    out_data[o*DATA_W +: DATA_W] <= oflit[o];
                    out_sel[o*3 +: 3]            <= win[o];
                    rr[o] <= (win[o] == 3'd4) ? 5'b00001 : 5'(5'b00010 << win[o]);
                end
                // A return paired with a grant is a straight swap of one slot.
                if (hit[o] && !credit_ret[o])
                    cred[o] <= cred[o] - 1'b1;
                else if (!hit[o] && credit_ret[o]) begin
                    if (cred[o] == CFULL)
                        credit_err <= 1'b1;
                    else
                        cred[o] <= cred[o] + 1'b1;
                end
            end
        end
    end
endmodule
